// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// Owner and FSM encodings are fixed so the response path and the bench agree on them.
package imem_dmem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REQ_ADDR_W = 32;
    localparam int unsigned STARVE_W   = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_D    = 2'b10
    } owner_e;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Response bookkeeping captured in the grant cycle, consumed one cycle later
    typedef struct packed {
        owner_e owner;
        logic   err;
        logic   store;
    } rsp_t;

    // True when no address bits above the memory index are set
    function automatic logic addr_in_range(input logic [REQ_ADDR_W-1:0] addr,
                                           input int unsigned           aw);
        return (addr >> aw) == '0;
    endfunction

endpackage

// File: rtl/imem_dmem_arbiter_starve_ctr.sv
// Saturating starvation counter for the fetch port; at_max is registered
// alongside the count so the grant logic sees a clean flop output.
module arb_starve_ctr
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [STARVE_W-1:0] cnt;
    logic [STARVE_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (inc && (cnt != STARVE_W'(MAX))) begin
            cnt_nxt = cnt + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            at_max <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            at_max <= (cnt_nxt == STARVE_W'(MAX));
        end
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates a single-port synchronous-read memory between instruction fetch and
// load/store; one access per cycle, responses exactly one cycle after grant.
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned STARVE_MAX  = 3,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [31:0]           d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_e            state;
    state_e            state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic              at_max;
    logic              if_ok;
    logic              d_ok;
    rsp_t              rsp_q;

    assign if_ok = addr_in_range(if_addr, ADDR_W);
    assign d_ok  = addr_in_range(d_addr, ADDR_W);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Next state: leave HOLD on the HOLD_CYCLES-th edge after reset release
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        if (state == ST_HOLD) begin
            if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                state_nxt = ST_RUN;
            end else begin
                hold_nxt = hold_cnt + HOLD_W'(1);
            end
        end
    end

    // Grant and memory strobe; D wins contention unless fetch has starved
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == ST_RUN) begin
            if_gnt = if_req && (!d_req || at_max);
            d_gnt  = d_req && !if_gnt;
            if (if_gnt) begin
                mem_en   = if_ok;
                mem_addr = if_addr[ADDR_W-1:0];
            end else if (d_gnt) begin
                mem_en    = d_ok;
                mem_we    = d_we;
                mem_addr  = d_addr[ADDR_W-1:0];
                mem_wdata = d_wdata;
            end
        end
    end

    arb_starve_ctr #(
        .MAX(STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   ((state == ST_RUN) && if_req && !if_gnt),
        .clr   (if_gnt),
        .at_max(at_max)
    );

    // Response owner; reset drops any response still in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q <= '0;
        end else begin
            rsp_q.owner <= if_gnt ? OWN_IF : (d_gnt ? OWN_D : OWN_NONE);
            rsp_q.err   <= (if_gnt && !if_ok) || (d_gnt && !d_ok);
            rsp_q.store <= d_gnt && d_we;
        end
    end

    assign if_rvalid = (rsp_q.owner == OWN_IF);
    assign d_rvalid  = (rsp_q.owner == OWN_D);
    assign if_err    = if_rvalid && rsp_q.err;
    assign d_err     = d_rvalid && rsp_q.err;
    assign if_rdata  = (if_rvalid && !rsp_q.err) ? mem_rdata : '0;
    assign d_rdata   = (d_rvalid && !rsp_q.err && !rsp_q.store) ? mem_rdata : '0;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: hold-off after reset, fetch streaming,
// store/load, out-of-range errors, starvation rotation and mid-flight reset.
module tb_imem_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_en;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] tb_mem [64];
    int          checks = 0;
    int          errors = 0;

    imem_dmem_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .if_err   (if_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: registered read, write on strobe
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
        end
    end

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dd;
        logic        eig;
        logic        edg;
        logic        emen;
        logic        emwe;
        logic [5:0]  ema;
        logic        eirv;
        logic [31:0] eird;
        logic        eier;
        logic        edrv;
        logic [31:0] edrd;
        logic        eder;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input logic ir, input logic [31:0] ia,
                                input logic dr, input logic dw,
                                input logic [31:0] da, input logic [31:0] dd,
                                input logic eig, input logic edg,
                                input logic emen, input logic emwe, input logic [5:0] ema,
                                input logic eirv, input logic [31:0] eird, input logic eier,
                                input logic edrv, input logic [31:0] edrd, input logic eder);
        vec_t v;
        v.ir = ir;     v.ia = ia;     v.dr = dr;     v.dw = dw;
        v.da = da;     v.dd = dd;     v.eig = eig;   v.edg = edg;
        v.emen = emen; v.emwe = emwe; v.ema = ema;
        v.eirv = eirv; v.eird = eird; v.eier = eier;
        v.edrv = edrv; v.edrd = edrd; v.eder = eder;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " flags"}, 32'({if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_en, mem_we}), 32'd0);
        chk({tag, " if_rdata"}, if_rdata, 32'd0);
        chk({tag, " d_rdata"}, d_rdata, 32'd0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dw, input logic [31:0] da, input logic [31:0] dd);
        if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) tb_mem[i] = 32'hA5A5_0000 | 32'(i);

        // Stimulus table: one record per cycle; response fields refer to the previous grant
        vecs[0]  = mk(1, 1, 0, 0, 0, 0,               1, 0, 1, 0, 1,  1, 32'hA5A50000, 0, 0, 0, 0);
        vecs[1]  = mk(1, 2, 0, 0, 0, 0,               1, 0, 1, 0, 2,  1, 32'hA5A50001, 0, 0, 0, 0);
        vecs[2]  = mk(1, 3, 0, 0, 0, 0,               1, 0, 1, 0, 3,  1, 32'hA5A50002, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0,  1, 32'hA5A50003, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 1, 1, 5, 32'hDEADBEEF,    0, 1, 1, 1, 5,  0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 0, 1, 0, 5, 0,               0, 1, 1, 0, 5,  0, 0, 0, 1, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0,  0, 0, 0, 1, 32'hDEADBEEF, 0);
        vecs[7]  = mk(0, 0, 1, 0, 32'h40, 0,          0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1);
        vecs[9]  = mk(1, 32'h80, 0, 0, 0, 0,          1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0);
        vecs[11] = mk(1, 7, 1, 0, 8, 0,               0, 1, 1, 0, 8,  0, 0, 0, 0, 0, 0);
        vecs[12] = mk(1, 7, 1, 0, 8, 0,               0, 1, 1, 0, 8,  0, 0, 0, 1, 32'hA5A50008, 0);
        vecs[13] = mk(1, 7, 1, 0, 8, 0,               0, 1, 1, 0, 8,  0, 0, 0, 1, 32'hA5A50008, 0);
        vecs[14] = mk(1, 7, 1, 0, 8, 0,               1, 0, 1, 0, 7,  0, 0, 0, 1, 32'hA5A50008, 0);
        vecs[15] = mk(1, 7, 1, 0, 8, 0,               0, 1, 1, 0, 8,  1, 32'hA5A50007, 0, 0, 0, 0);
        vecs[16] = mk(1, 7, 1, 0, 8, 0,               0, 1, 1, 0, 8,  0, 0, 0, 1, 32'hA5A50008, 0);
        vecs[17] = mk(1, 7, 1, 0, 8, 0,               0, 1, 1, 0, 8,  0, 0, 0, 1, 32'hA5A50008, 0);
        vecs[18] = mk(1, 7, 1, 0, 8, 0,               1, 0, 1, 0, 7,  0, 0, 0, 1, 32'hA5A50008, 0);
        vecs[19] = mk(0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0,  1, 32'hA5A50007, 0, 0, 0, 0);

        // Reset with both requesters active: every output must stay quiet
        rst_n = 1'b0;
        drive(1, 0, 1, 1, 3, 32'hFFFFFFFF);
        repeat (2) @(negedge clk);
        #1 chk_all_zero("reset");

        // Release reset; fetch must wait out the hold window
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0);
        #1 chk("hold c1 if_gnt", 32'(if_gnt), 32'd0);
        @(negedge clk);
        #1 chk("hold c2 if_gnt", 32'(if_gnt), 32'd0);
        @(negedge clk);
        #1 chk("run c3 if_gnt", 32'(if_gnt), 32'd1);
        chk("run c3 mem_en", 32'(mem_en), 32'd1);
        chk("run c3 mem_addr", 32'(mem_addr), 32'd0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dd);
            #1;
            chk($sformatf("v%0d if_gnt", i), 32'(if_gnt), 32'(vecs[i].eig));
            chk($sformatf("v%0d d_gnt", i), 32'(d_gnt), 32'(vecs[i].edg));
            chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(vecs[i].emen));
            if (vecs[i].eig || vecs[i].edg) begin
                chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].ema));
                chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].emwe));
            end
            if (vecs[i].edg) chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].dd);
            chk($sformatf("v%0d if_rvalid", i), 32'(if_rvalid), 32'(vecs[i].eirv));
            chk($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].eird);
            chk($sformatf("v%0d if_err", i), 32'(if_err), 32'(vecs[i].eier));
            chk($sformatf("v%0d d_rvalid", i), 32'(d_rvalid), 32'(vecs[i].edrv));
            chk($sformatf("v%0d d_rdata", i), d_rdata, vecs[i].edrd);
            chk($sformatf("v%0d d_err", i), 32'(d_err), 32'(vecs[i].eder));
        end

        // Reset after a fetch grant: response dropped, hold window restarts
        @(negedge clk);
        drive(1, 2, 0, 0, 0, 0);
        #1 chk("mid gnt", 32'(if_gnt), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("mid rst a");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1 chk_all_zero($sformatf("mid rst %0d", i));
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rehold c1 if_gnt", 32'(if_gnt), 32'd0);
        chk("rehold c1 if_rvalid", 32'(if_rvalid), 32'd0);
        @(negedge clk);
        #1 chk("rehold c2 if_gnt", 32'(if_gnt), 32'd0);
        chk("rehold c2 if_rvalid", 32'(if_rvalid), 32'd0);
        @(negedge clk);
        #1 chk("rerun if_gnt", 32'(if_gnt), 32'd1);
        chk("rerun mem_addr", 32'(mem_addr), 32'd2);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1 chk("rerun if_rvalid", 32'(if_rvalid), 32'd1);
        chk("rerun if_rdata", if_rdata, 32'hA5A50002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port, synchronous-read word memory (64 words, `$readmemb`-initialised, read data registered on `posedge clk`) between two requesters.
- Requester one is the instruction-fetch port (IF); requester two is the load/store data port (D).
- Sits between the processor datapath and the memory. Issues at most one access per cycle, returns read data with fixed latency, and guarantees fetch forward progress under data-port contention.

Parameters:
- ADDR_W, 6, word-index width; memory depth is 2**ADDR_W words.
- DATA_W, 32, data word width.
- STARVE_MAX, 3, consecutive contended cycles IF may lose before it is forced to win (range 1..15).
- HOLD_CYCLES, 2, cycles after reset release during which no grants are issued (memory init settle).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request, held until granted.
- if_addr  in  32  fetch word address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid pulse.
- if_rdata  out  DATA_W  fetch data.
- if_err  out  1  with if_rvalid: address out of range.
- d_req  in  1  data request, held until granted.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data word address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data accepted this cycle.
- d_rvalid  out  1  load data / store ack pulse.
- d_rdata  out  DATA_W  load data (0 for stores).
- d_err  out  1  with d_rvalid: address out of range.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word index.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0.
  - State = HOLD, hold counter = 0, starve counter = 0, response owner = NONE.
- FSM HOLD -> RUN:
  - HOLD: gnt outputs 0, requests ignored (not lost; requesters keep holding).
  - After HOLD_CYCLES rising edges with rst_n=1, go to RUN.
  - RUN stays RUN until reset.
- Grant (RUN, combinational from current req and registered starve counter; one grant max per cycle):
  - Only one requester active: it is granted.
  - Both active and starve_cnt < STARVE_MAX: D wins.
  - Both active and starve_cnt == STARVE_MAX: IF wins.
- Starve counter:
  - Increments when if_req=1 and IF is not granted in RUN, saturating at STARVE_MAX.
  - Clears on if_gnt.
  - Unchanged when if_req=0.
- Memory access: in the grant cycle, mem_en=1, mem_addr=addr[ADDR_W-1:0], mem_we=d_we&d_gnt, mem_wdata=d_wdata.
- Out-of-range access (addr[31:ADDR_W]!=0):
  - Still granted, but mem_en=0.
  - Response next cycle has err=1, rdata=0.
- Response latency is exactly 1 cycle after gnt:
  - The registered owner selects which rvalid pulses, for one cycle.
  - rdata = mem_rdata for in-range loads/fetches; 0 for stores and errors.
  - The non-owner's rvalid stays 0.
- Throughput: back-to-back grants on consecutive cycles allowed; responses pipeline one per cycle.
- Reset mid-operation: a pending response is discarded (no rvalid after reset); the memory write, if already strobed, is not undone.
- Requests asserted in the same cycle as reset deassertion are not granted until RUN.

Decomposition:
- Shared package:
  - ADDR_W and DATA_W defaults.
  - Owner encoding: NONE=2'b00, IF=2'b01, D=2'b10.
  - FSM encoding: HOLD=1'b0, RUN=1'b1.
- One natural sub-module: arb_starve_ctr, a saturating counter with inc/clr and an at_max flag.

Test Plan:
- Reset, HOLD_CYCLES=2, if_req=1 from t0 -> if_gnt=0 for 2 cycles after rst_n rises, if_gnt=1 on cycle 3, if_rvalid with Mem[0] on cycle 4.
- IF only, if_addr=0,1,2,3 on consecutive cycles -> if_gnt every cycle, if_rvalid on 4 consecutive cycles carrying Mem[0..3] in order.
- d_req store, addr 5, wdata 32'hDEADBEEF, then load addr 5 -> store ack d_rvalid with d_rdata=0; load returns 32'hDEADBEEF.
- Both requesters held high continuously, STARVE_MAX=3 -> grant pattern D,D,D,IF repeating; starve counter never exceeds 3.
- d_addr=32'h0000_0040 load -> d_gnt=1, mem_en=0, next cycle d_rvalid=1, d_err=1, d_rdata=0.
- rst_n pulsed low the cycle after if_gnt -> no if_rvalid; all outputs 0 during reset; FSM returns to HOLD.
